// File: rtl/custom_ip_reg_bridge.sv
// APB register frontend launching per-channel four-phase req/ack writes toward the IP core.
// Latency: APB zero wait state; req rises the cycle after a WDATA write; irq lags flags by one cycle.
// Backpressure: a WDATA write to a busy channel is refused with pslverr; read capture never stalls.
module custom_ip_reg_bridge #(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               paddr_i,
    input  logic                     psel_i,
    input  logic                     penable_i,
    input  logic                     pwrite_i,
    input  logic [31:0]              pwdata_i,
    output logic [31:0]              prdata_o,
    output logic                     pready_o,
    output logic                     pslverr_o,
    output logic [NUM_CH*DATA_W-1:0] reg2ip_data_o,
    output logic [NUM_CH-1:0]        reg2ip_req_o,
    input  logic [NUM_CH-1:0]        reg2ip_ack_i,
    input  logic [NUM_CH*DATA_W-1:0] ip2reg_data_i,
    input  logic [NUM_CH-1:0]        ip2reg_valid_i,
    output logic                     irq_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    logic       access;
    logic       wr_acc;
    logic       rd_acc;
    logic [5:0] word;
    logic [1:0] ch;
    logic       ch_ok;
    logic       hit_wdata;
    logic       hit_rdata;
    logic       hit_status;
    logic       hit_clear;
    logic       hit_irqen;
    logic       mapped;
    logic       busy_sel;
    logic       unused_paddr;

    assign access     = psel_i & penable_i;
    assign wr_acc     = access & pwrite_i;
    assign rd_acc     = access & ~pwrite_i;
    assign word       = paddr_i[7:2];
    assign ch         = word[1:0];
    assign ch_ok      = (int'(ch) < NUM_CH);
    assign hit_wdata  = (word[5:2] == 4'd0) & ch_ok;
    assign hit_rdata  = (word[5:2] == 4'd1) & ch_ok;
    assign hit_status = (word == 6'd8);
    assign hit_clear  = (word == 6'd9);
    assign hit_irqen  = (word == 6'd10);
    assign mapped     = hit_wdata | hit_rdata | hit_status | hit_clear | hit_irqen;
    // Byte-lane bits carry no information for a word-only register map.
    assign unused_paddr = ^paddr_i[1:0];

    assign pready_o = 1'b1;

    // ---------------------------------------------------------------
    // Per-channel state
    // ---------------------------------------------------------------
    state_t              state_q [NUM_CH];
    state_t              state_d [NUM_CH];
    logic [CNT_W-1:0]    cnt_q   [NUM_CH];
    logic [CNT_W-1:0]    cnt_d   [NUM_CH];
    logic [DATA_W-1:0]   data_q  [NUM_CH];
    logic [DATA_W-1:0]   data_d  [NUM_CH];
    logic [DATA_W-1:0]   shadow_q[NUM_CH];
    logic [NUM_CH-1:0]   tout_q;
    logic [NUM_CH-1:0]   tout_d;
    logic [NUM_CH-1:0]   busy;
    logic [NUM_CH-1:0]   wdata_accept;
    logic [NUM_CH-1:0]   rdata_read;
    logic [NUM_CH-1:0]   done_set;
    logic [NUM_CH-1:0]   tout_set;

    // Flags and interrupt enable
    logic [NUM_CH-1:0]   done_q;
    logic [NUM_CH-1:0]   timeout_q;
    logic [NUM_CH-1:0]   rvalid_q;
    logic [NUM_CH-1:0]   clr_done;
    logic [NUM_CH-1:0]   clr_tout;
    logic [NUM_CH-1:0]   clr_rvalid;
    logic [2:0]          en_q;
    logic                irq_q;

    // Per-channel strobes for accepted writes, shadow reads and the busy bit of the addressed channel
    always_comb begin
        busy         = '0;
        wdata_accept = '0;
        rdata_read   = '0;
        busy_sel     = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            busy[n] = (state_q[n] != ST_IDLE);
            if (ch == 2'(n)) begin
                busy_sel = (state_q[n] != ST_IDLE);
            end
            wdata_accept[n] = wr_acc & hit_wdata & (ch == 2'(n)) & (state_q[n] == ST_IDLE);
            rdata_read[n]   = rd_acc & hit_rdata & (ch == 2'(n));
        end
    end

    assign clr_done   = (wr_acc & hit_clear) ? pwdata_i[8  +: NUM_CH] : '0;
    assign clr_tout   = (wr_acc & hit_clear) ? pwdata_i[16 +: NUM_CH] : '0;
    assign clr_rvalid = ((wr_acc & hit_clear) ? pwdata_i[24 +: NUM_CH] : '0) | rdata_read;

    // Write handshake FSM next-state: latch data on accept, supervise REQ with a timeout, wait for ack release
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        tout_d   = tout_q;
        done_set = '0;
        tout_set = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            case (state_q[n])
                ST_IDLE: begin
                    if (wdata_accept[n]) begin
                        state_d[n] = ST_REQ;
                        data_d[n]  = pwdata_i[DATA_W-1:0];
                        // Count starts at 1 so req stays high exactly TIMEOUT cycles on no-ack.
                        cnt_d[n]   = CNT_W'(1);
                        tout_d[n]  = 1'b0;
                    end
                end
                ST_REQ: begin
                    if (reg2ip_ack_i[n]) begin
                        state_d[n] = ST_RELEASE;
                    end else if (cnt_q[n] == CNT_W'(TIMEOUT)) begin
                        state_d[n]  = ST_RELEASE;
                        tout_d[n]   = 1'b1;
                        tout_set[n] = 1'b1;
                    end else begin
                        cnt_d[n] = cnt_q[n] + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // A late ack after a timeout is absorbed here without reporting completion.
                    if (!reg2ip_ack_i[n]) begin
                        state_d[n]  = ST_IDLE;
                        done_set[n] = ~tout_q[n];
                    end
                end
                default: begin
                    state_d[n] = ST_IDLE;
                end
            endcase
        end
    end

    // Handshake state registers; reset drops req immediately and discards any transfer in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < NUM_CH; n++) begin
                state_q[n] <= ST_IDLE;
                cnt_q[n]   <= '0;
                data_q[n]  <= '0;
            end
            tout_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            tout_q  <= tout_d;
        end
    end

    // Shadow capture of IP read data whenever the per-channel qualifier is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < NUM_CH; n++) begin
                shadow_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (ip2reg_valid_i[n]) begin
                    shadow_q[n] <= ip2reg_data_i[n*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Sticky flags; a set in the same cycle as a clear takes priority
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q    <= '0;
            timeout_q <= '0;
            rvalid_q  <= '0;
        end else begin
            done_q    <= done_set       | (done_q    & ~clr_done);
            timeout_q <= tout_set       | (timeout_q & ~clr_tout);
            rvalid_q  <= ip2reg_valid_i | (rvalid_q  & ~clr_rvalid);
        end
    end

    // Interrupt enable register and registered level interrupt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (wr_acc & hit_irqen) begin
                en_q <= pwdata_i[2:0];
            end
            irq_q <= (|(done_q & {NUM_CH{en_q[0]}})) |
                     (|(timeout_q & {NUM_CH{en_q[1]}})) |
                     (|(rvalid_q & {NUM_CH{en_q[2]}}));
        end
    end

    assign irq_o = irq_q;

    // Drive the IP-side request and data buses from the channel registers
    always_comb begin
        reg2ip_req_o  = '0;
        reg2ip_data_o = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            reg2ip_req_o[n]                      = (state_q[n] == ST_REQ);
            reg2ip_data_o[n*DATA_W +: DATA_W]    = data_q[n];
        end
    end

    // APB read mux and error response; both are forced to 0 outside the access phase
    always_comb begin
        logic [31:0] rd_mux;
        rd_mux = '0;
        if (hit_status) begin
            for (int n = 0; n < NUM_CH; n++) begin
                rd_mux[n]      = busy[n];
                rd_mux[8 + n]  = done_q[n];
                rd_mux[16 + n] = timeout_q[n];
                rd_mux[24 + n] = rvalid_q[n];
            end
        end else if (hit_irqen) begin
            rd_mux = {29'd0, en_q};
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (hit_wdata && (ch == 2'(n))) begin
                    rd_mux = 32'(data_q[n]);
                end
                if (hit_rdata && (ch == 2'(n))) begin
                    rd_mux = 32'(shadow_q[n]);
                end
            end
        end
        prdata_o  = rd_acc ? rd_mux : 32'd0;
        pslverr_o = access & (~mapped | (pwrite_i & hit_wdata & busy_sel));
    end

endmodule

// File: tb/tb_custom_ip_reg_bridge.sv
// Scoreboarded bench for custom_ip_reg_bridge: APB responses and req pulses are
// queued by the stimulus and checked by independent monitors on the falling edge.
module tb_custom_ip_reg_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [95:0] reg2ip_data;
    logic [2:0]  reg2ip_req;
    logic [2:0]  reg2ip_ack = '0;
    logic [95:0] ip2reg_data = '0;
    logic [2:0]  ip2reg_valid = '0;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] rd;
        logic        err;
    } apb_exp_t;

    typedef struct packed {
        logic [1:0]  ch;
        logic [7:0]  dur;
        logic [31:0] dat;
    } req_exp_t;

    apb_exp_t apb_q[$];
    string    apb_nm[$];
    req_exp_t req_q[$];

    always #5 clk = ~clk;

    custom_ip_reg_bridge #(
        .NUM_CH (3),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .paddr_i       (paddr),
        .psel_i        (psel),
        .penable_i     (penable),
        .pwrite_i      (pwrite),
        .pwdata_i      (pwdata),
        .prdata_o      (prdata),
        .pready_o      (pready),
        .pslverr_o     (pslverr),
        .reg2ip_data_o (reg2ip_data),
        .reg2ip_req_o  (reg2ip_req),
        .reg2ip_ack_i  (reg2ip_ack),
        .ip2reg_data_i (ip2reg_data),
        .ip2reg_valid_i(ip2reg_valid),
        .irq_o         (irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // side: 0 none, 1 pulse ip2reg_valid[0] during access, 2 drop ack[0] at access start
    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input string nm, input int side);
        apb_exp_t e;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        e.wr = wr; e.rd = exp_rd; e.err = exp_err;
        apb_q.push_back(e);
        apb_nm.push_back(nm);
        penable = 1'b1;
        if (side == 1) ip2reg_valid[0] = 1'b1;
        if (side == 2) reg2ip_ack[0] = 1'b0;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        if (side == 1) ip2reg_valid[0] = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic err, input string nm);
        apb(1'b1, a, d, 32'd0, err, nm, 0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input logic err, input string nm);
        apb(1'b0, a, 32'd0, exp, err, nm, 0);
    endtask

    task automatic push_req(input logic [1:0] c, input logic [7:0] dur, input logic [31:0] dat);
        req_exp_t r;
        r.ch = c; r.dur = dur; r.dat = dat;
        req_q.push_back(r);
    endtask

    task automatic wait_req_low(input int c, input string nm);
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!reg2ip_req[c]) break;
        end
        chk(nm, 32'(k < 30), 32'd1);
    endtask

    // APB response monitor
    apb_exp_t m_e;
    string    m_nm;
    always @(negedge clk) begin
        if (psel && penable) begin
            total++;
            if (apb_q.size() == 0) begin
                bad++;
                $display("FAIL apb_unexpected addr=%h", paddr);
            end else begin
                m_e  = apb_q.pop_front();
                m_nm = apb_nm.pop_front();
                if (pslverr !== m_e.err) begin
                    bad++;
                    $display("FAIL %s_err got=%b expected=%b", m_nm, pslverr, m_e.err);
                end
                if (!m_e.wr) begin
                    total++;
                    if (prdata !== m_e.rd) begin
                        bad++;
                        $display("FAIL %s_rd got=%h expected=%h", m_nm, prdata, m_e.rd);
                    end
                end
            end
        end
    end

    // req pulse monitor: width in cycles and data present when req first rises
    int          hi_cnt[3] = '{0, 0, 0};
    logic [31:0] hi_dat[3];
    req_exp_t    m_r;
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (reg2ip_req[c]) begin
                if (hi_cnt[c] == 0) hi_dat[c] = reg2ip_data[c*32 +: 32];
                hi_cnt[c]++;
            end else if (hi_cnt[c] != 0) begin
                total++;
                if (req_q.size() == 0) begin
                    bad++;
                    $display("FAIL req_unexpected ch=%0d width=%0d", c, hi_cnt[c]);
                end else begin
                    m_r = req_q.pop_front();
                    if (int'(m_r.ch) != c || int'(m_r.dur) != hi_cnt[c] || m_r.dat !== hi_dat[c]) begin
                        bad++;
                        $display("FAIL req_pulse got ch=%0d width=%0d data=%h expected ch=%0d width=%0d data=%h",
                                 c, hi_cnt[c], hi_dat[c], m_r.ch, m_r.dur, m_r.dat);
                    end
                end
                hi_cnt[c] = 0;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(reg2ip_req), 32'd0);
        chk("rst_data_lo", reg2ip_data[31:0], 32'd0);
        chk("rst_data_hi", reg2ip_data[95:64], 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_pready", 32'(pready), 32'd1);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(8'h20, 32'h0, 1'b0, "rst_status");

        // Normal handshake on channel 1: ack 3 cycles after req, dropped 2 cycles later
        push_req(2'd1, 8'd4, 32'h1234_5678);
        wr(8'h04, 32'h1234_5678, 1'b0, "t2_wr");
        repeat (3) @(posedge clk); #1;
        reg2ip_ack[1] = 1'b1;
        repeat (2) @(posedge clk); #1;
        reg2ip_ack[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t2_data", reg2ip_data[63:32], 32'h1234_5678);
        rd(8'h20, 32'h0000_0200, 1'b0, "t2_status");
        rd(8'h04, 32'h1234_5678, 1'b0, "t2_wdata_rb");
        wr(8'h24, 32'h0000_0200, 1'b0, "t2_clear");
        rd(8'h20, 32'h0, 1'b0, "t2_status_clr");

        // Timeout on channel 0 with timeout interrupt enabled
        wr(8'h28, 32'h2, 1'b0, "t3_irqen");
        rd(8'h28, 32'h2, 1'b0, "t3_irqen_rb");
        push_req(2'd0, 8'd8, 32'hCAFE_0001);
        wr(8'h00, 32'hCAFE_0001, 1'b0, "t3_wr");
        wait_req_low(0, "t3_req_fell");
        chk("t3_irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t3_irq_set", 32'(irq), 32'd1);
        rd(8'h20, 32'h0001_0000, 1'b0, "t3_status");
        wr(8'h24, 32'h0001_0000, 1'b0, "t3_clear");
        @(negedge clk);
        chk("t3_irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        chk("t3_irq_clr", 32'(irq), 32'd0);
        wr(8'h28, 32'h0, 1'b0, "t3_irqen_off");

        // Busy refusal, unmapped accesses, late ack absorbed after timeout on channel 2
        push_req(2'd2, 8'd8, 32'hAAAA_0002);
        wr(8'h08, 32'hAAAA_0002, 1'b0, "t4_wr");
        wr(8'h08, 32'hBBBB_0003, 1'b1, "t4_wr_busy");
        @(negedge clk);
        chk("t4_data_held", reg2ip_data[95:64], 32'hAAAA_0002);
        wait_req_low(2, "t4_req_fell");
        reg2ip_ack[2] = 1'b1;
        rd(8'h0C, 32'h0, 1'b1, "t4_rd_ch3");
        wr(8'h3C, 32'h1, 1'b1, "t4_wr_3c");
        rd(8'h3C, 32'h0, 1'b1, "t4_rd_3c");
        rd(8'h20, 32'h0004_0004, 1'b0, "t4_status_rel");
        @(posedge clk); #1;
        reg2ip_ack[2] = 1'b0;
        repeat (3) @(posedge clk);
        rd(8'h20, 32'h0004_0000, 1'b0, "t4_status_end");
        wr(8'h24, 32'h0004_0000, 1'b0, "t4_clear");

        // Read capture and read-clears-rvalid, then valid coinciding with the read
        @(posedge clk); #1;
        ip2reg_data[31:0] = 32'h0000_2468;
        ip2reg_valid[0] = 1'b1;
        @(posedge clk); #1;
        ip2reg_valid[0] = 1'b0;
        rd(8'h20, 32'h0100_0000, 1'b0, "t5_status_rv");
        rd(8'h10, 32'h0000_2468, 1'b0, "t5_rdata");
        rd(8'h20, 32'h0, 1'b0, "t5_status_rd_clr");
        ip2reg_data[31:0] = 32'h0000_1357;
        apb(1'b0, 8'h10, 32'h0, 32'h0000_2468, 1'b0, "t5_rd_coinc", 1);
        rd(8'h20, 32'h0100_0000, 1'b0, "t5_status_set_wins");
        rd(8'h10, 32'h0000_1357, 1'b0, "t5_rdata_new");

        // CLEAR of done[0] in the same cycle channel 0 completes
        push_req(2'd0, 8'd1, 32'h1111_0000);
        wr(8'h00, 32'h1111_0000, 1'b0, "t6_wr");
        reg2ip_ack[0] = 1'b1;
        apb(1'b1, 8'h24, 32'h0000_0100, 32'h0, 1'b0, "t6_clear", 2);
        rd(8'h20, 32'h0000_0100, 1'b0, "t6_status");

        // Asynchronous reset in the middle of a request
        wr(8'h28, 32'h5, 1'b0, "t7_irqen");
        push_req(2'd1, 8'd2, 32'h0BAD_0001);
        wr(8'h04, 32'h0BAD_0001, 1'b0, "t7_wr");
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_req_drop", 32'(reg2ip_req), 32'd0);
        chk("t7_data_rst", reg2ip_data[63:32], 32'd0);
        chk("t7_irq_rst", 32'(irq), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(8'h20, 32'h0, 1'b0, "t7_status");
        rd(8'h28, 32'h0, 1'b0, "t7_irqen");
        rd(8'h10, 32'h0, 1'b0, "t7_shadow");

        repeat (5) @(posedge clk);
        chk("apb_q_drained", 32'(apb_q.size()), 32'd0);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/custom_ip_reg_bridge.md
# custom_ip_reg_bridge

APB-facing register frontend that sits directly upstream of the custom IP core and drives its per-channel register-to-IP write handshake. Each bus write to a channel's data register launches a four-phase req/ack transfer toward the IP, supervised by a per-channel timeout. The block continuously captures the IP's per-channel read data into shadow registers, which the bus reads back. Status flags and a maskable interrupt report completion, timeout and new read data.

## Interface
Parameters:
- NUM_CH, 3: number of write/read channels (1..4).
- DATA_W, 32: channel data width.
- TIMEOUT, 255: cycles to wait for ack before abort (1..65535); counter width is $clog2(TIMEOUT+1).

Ports:
- clk_i  in  1  sole clock; all logic on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- paddr_i  in  8  APB byte address; bits [1:0] ignored.
- psel_i, penable_i, pwrite_i  in  1 each  APB control.
- pwdata_i  in  32  APB write data.
- prdata_o  out  32  APB read data; valid in the access phase.
- pready_o  out  1  tied 1 (zero wait state).
- pslverr_o  out  1  error response; valid in the access phase.
- reg2ip_data_o  out  NUM_CH*DATA_W  per-channel write data, held stable while req is high.
- reg2ip_req_o  out  NUM_CH  per-channel write request.
- reg2ip_ack_i  in  NUM_CH  per-channel acknowledge from the IP.
- ip2reg_data_i  in  NUM_CH*DATA_W  per-channel read data from the IP.
- ip2reg_valid_i  in  NUM_CH  per-channel read-data-valid qualifier.
- irq_o  out  1  registered, level interrupt.

## Operation
- Access: psel_i & penable_i. Writes commit on that clock edge.
- Address map:
  - 0x00+4n WDATA[n] (RW).
  - 0x10+4n RDATA[n] (RO).
  - 0x20 STATUS (RO): [3:0] busy, [11:8] done, [19:16] timeout, [27:24] rvalid.
  - 0x24 CLEAR (W1C for done/timeout/rvalid, same bit positions as STATUS).
  - 0x28 IRQ_EN: [0] done, [1] timeout, [2] rvalid.
  - Unmapped addresses and channels n ≥ NUM_CH: read 0, pslverr_o=1, writes have no effect.
- Per-channel write FSM:
  - IDLE: a WDATA[n] write latches pwdata_i[DATA_W-1:0] and moves to REQ.
  - REQ: req=1, count increments. If ack=1, go to RELEASE. Else, when count==TIMEOUT, set timeout and go to RELEASE.
  - RELEASE: req=0. Wait for ack=0, then go to IDLE; set done only if the channel did not time out.
  - busy[n] = state != IDLE.
- A WDATA[n] write while busy: pslverr_o=1, data and state unchanged.
- Read capture: every cycle with ip2reg_valid_i[n]=1, the shadow register takes ip2reg_data_i[n] and rvalid[n] is set. A bus read of RDATA[n] returns the shadow and clears rvalid[n].
- Simultaneous set and clear (CLEAR write or RDATA read) on the same flag: set wins.
- irq_o = |(done & {NUM_CH{en[0]}}) | |(timeout & en[1]) | |(rvalid & en[2]), registered.
- Reset values: all state IDLE; reg2ip_req_o=0; reg2ip_data_o=0; shadows, flags and IRQ_EN all 0; irq_o=0; prdata_o=0 and pslverr_o=0 outside access.

## Timing
- Write access at edge T: reg2ip_data_o and reg2ip_req_o are high from T+1.
- ack first sampled high at edge A: req low from A+1.
- ack sampled low at edge B while in RELEASE: done visible from B+1; busy=0 from B+1.
- A new WDATA write is accepted at B+1 at the earliest.
- Timeout: no ack → req is high exactly TIMEOUT cycles; timeout flag visible the cycle req falls.
- An ack arriving after timeout is absorbed in RELEASE; done is not set.
- Read capture: valid at edge V → RDATA readable from V+1.
- irq_o lags its flag by one cycle.
- Asynchronous reset mid-handshake: req drops immediately and the transfer is lost.

## Test plan
- Reset: all outputs 0, STATUS=0, pready_o=1.
- Write 0x1234_5678 to 0x04 with ack asserted 3 cycles after req and dropped 2 cycles later → reg2ip_data_o[63:32]=0x12345678, req high 4 cycles, STATUS.done[1]=1, busy[1]=0.
- TIMEOUT=8, write 0x00 with ack held 0 → req high exactly 8 cycles, STATUS=0x0001_0000; with IRQ_EN=0x2, irq_o=1 one cycle later; CLEAR 0x0001_0000 → irq_o=0.
- Second write to 0x08 while channel 2 busy → pslverr_o=1, reg2ip_data_o unchanged; access to 0x0C (NUM_CH=3) or 0x3C → pslverr_o=1, prdata_o=0.
- ip2reg_valid_i[0] pulse with data 0x2468 → RDATA[0] (0x10)=0x2468, rvalid[0] clears after read; valid on the same cycle as the read leaves rvalid=1 holding the new data.
- Write CLEAR for done[0] on the same cycle channel 0 completes → done[0] remains 1.
